// File: rtl/mb_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : mb_tx_if
//  Description : Adapter-side flit handshake for the mainband transmitter.
//                master  - adapter side: drives valid_i/data_i, sees ready_o
//                slave   - mb_tx side:   sees valid_i/data_i, drives ready_o
//                valid_i  1    flit valid
//                data_i   512  flit, byte n = data_i[8n+7:8n]
//                ready_o  1    transmitter FIFO can accept a flit
//  Revision    : 1.0 - initial release
// ============================================================================
interface mb_tx_if;
    logic         valid_i;
    logic [511:0] data_i;
    logic         ready_o;

    modport master (output valid_i, output data_i, input  ready_o);
    modport slave  (input  valid_i, input  data_i, output ready_o);
endinterface
`default_nettype wire

// File: rtl/mb_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mb_tx
//  Description : UCIe mainband transmit serializer. Buffers 64-byte flits in
//                a FIFO and serializes each over 16 lanes in 32 UIs (one UI
//                per clk), with the 11110000 valid framing per 8-UI chunk and
//                the forwarded-clock enable.
//  Ports       : clk           UI-rate clock
//                reset         synchronous, active-high reset
//                bus           flit handshake (valid_i, data_i, ready_o)
//                dataPins_o    16 mainband data lanes
//                valid_oPin    mainband valid lane
//                clk_en_o      forwarded clock enable for the current UI
//                busy_o        serializing or FIFO non-empty
//                flits_sent_o  fully transmitted flits, wraps at 16 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module mb_tx #(
    parameter int FLIT_BUFFER_SIZE = 4   // power of 2, >= 2
) (
    input  wire         clk,
    input  wire         reset,
    mb_tx_if.slave      bus,
    output logic [15:0] dataPins_o,
    output logic        valid_oPin,
    output logic        clk_en_o,
    output logic        busy_o,
    output logic [15:0] flits_sent_o
);

    localparam int                 c_ptr_w = $clog2(FLIT_BUFFER_SIZE);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FLIT_BUFFER_SIZE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [511:0]        r_fifo [FLIT_BUFFER_SIZE];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_out_of_reset;
    state_t              r_state;
    logic [4:0]          r_ui;
    logic [511:0]        r_flit;
    logic [15:0]         r_pins;
    logic                r_valid;
    logic                r_clk_en;
    logic                r_busy;
    logic [15:0]         r_flits_sent;

    logic                w_push;
    logic                w_pop;
    logic                w_last_ui;
    logic                w_send_next;
    logic [c_cnt_w-1:0]  w_count_next;
    logic [4:0]          w_ui_inc;

    // Lane j at UI ui carries bit ui[2:0] of byte 16*ui[4:3]+j, whose flat
    // bit index 128*c + 8*j + b is just the concatenation {c, j, b}.
    function automatic logic [15:0] ui_bits(input logic [511:0] flit,
                                            input logic [4:0]   ui);
        logic [15:0] bits;
        bits = '0;
        for (int j = 0; j < 16; j++) begin
            bits[j] = flit[{ui[4:3], 4'(j), ui[2:0]}];
        end
        return bits;
    endfunction

    // ready is held low until the first edge after reset releases.
    assign bus.ready_o = r_out_of_reset && (r_count != c_depth);

    always_comb begin
        w_push       = bus.valid_i && bus.ready_o;
        w_last_ui    = (r_state == ST_SEND) && (r_ui == 5'd31);
        w_pop        = (r_count != '0) && ((r_state == ST_IDLE) || w_last_ui);
        w_send_next  = w_pop || ((r_state == ST_SEND) && !w_last_ui);
        w_count_next = r_count;
        if (w_push) w_count_next = w_count_next + c_cnt_one;
        if (w_pop)  w_count_next = w_count_next - c_cnt_one;
        w_ui_inc     = r_ui + 5'd1;
    end

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_out_of_reset <= 1'b0;
            r_state        <= ST_IDLE;
            r_ui           <= '0;
            r_flit         <= '0;
            r_pins         <= '0;
            r_valid        <= 1'b0;
            r_clk_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_flits_sent   <= '0;
        end else begin
            r_out_of_reset <= 1'b1;
            r_count        <= w_count_next;
            r_busy         <= w_send_next || (w_count_next != '0);
            if (w_push)    r_wr_ptr     <= r_wr_ptr + c_ptr_one;
            if (w_pop)     r_rd_ptr     <= r_rd_ptr + c_ptr_one;
            if (w_last_ui) r_flits_sent <= r_flits_sent + 16'd1;

            if (w_pop) begin
                // Drive UI 0 of the new flit directly from the FIFO head so
                // back-to-back flits leave no gap on the pins.
                r_state  <= ST_SEND;
                r_flit   <= r_fifo[r_rd_ptr];
                r_ui     <= 5'd0;
                r_pins   <= ui_bits(r_fifo[r_rd_ptr], 5'd0);
                r_valid  <= 1'b1;
                r_clk_en <= 1'b1;
            end else if ((r_state == ST_SEND) && !w_last_ui) begin
                r_ui     <= w_ui_inc;
                r_pins   <= ui_bits(r_flit, w_ui_inc);
                r_valid  <= !w_ui_inc[2];
                r_clk_en <= 1'b1;
            end else begin
                r_state  <= ST_IDLE;
                r_pins   <= '0;
                r_valid  <= 1'b0;
                r_clk_en <= 1'b0;
            end
        end
    end

    assign dataPins_o   = r_pins;
    assign valid_oPin   = r_valid;
    assign clk_en_o     = r_clk_en;
    assign busy_o       = r_busy;
    assign flits_sent_o = r_flits_sent;

endmodule
`default_nettype wire

// File: tb/tb_mb_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mb_tx
//  Description : Self-checking bench for mb_tx. A queue-based reference model
//                predicts every output each cycle; a lane deserializer
//                reassembles flits from the pins and compares them in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_tx;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] dataPins_o;
    logic        valid_oPin;
    logic        clk_en_o;
    logic        busy_o;
    logic [15:0] flits_sent_o;

    mb_tx_if bus ();

    mb_tx #(.FLIT_BUFFER_SIZE(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dataPins_o   (dataPins_o),
        .valid_oPin   (valid_oPin),
        .clk_en_o     (clk_en_o),
        .busy_o       (busy_o),
        .flits_sent_o (flits_sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [511:0] m_q[$];      // flits waiting in the FIFO
    logic [511:0] rx_q[$];     // flits expected on the pins, in order
    logic [511:0] m_cur;
    int           m_ui   = -1; // UI on the pins, -1 when idle
    int           m_sent = 0;
    bit           m_run  = 0;
    bit           m_acc  = 0;
    bit           m_can, m_last, r_in, v_in;
    logic [511:0] d_in;
    logic [15:0]  e_pins;
    logic [511:0] rx_flit;
    int           rx_ui = 0;
    int           en_cnt = 0, en_runs = 0, v_rises = 0;
    bit           prev_en = 0, prev_v = 0;

    always @(posedge clk) begin
        r_in = reset; v_in = bus.valid_i; d_in = bus.data_i;
        m_acc = 0;
        if (r_in) begin
            m_q.delete(); rx_q.delete();
            m_ui = -1; m_sent = 0; m_run = 0; rx_ui = 0;
        end else begin
            m_can  = m_run && (m_q.size() < DEPTH);
            m_last = (m_ui == 31);
            if (m_ui >= 0 && m_ui < 31) m_ui++;
            else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_ui = 0; rx_q.push_back(m_cur);
            end else m_ui = -1;
            if (m_last) m_sent = (m_sent + 1) % 65536;
            if (v_in && m_can) begin m_q.push_back(d_in); m_acc = 1; end
            m_run = 1;
        end
        #1;
        e_pins = '0;
        if (m_ui >= 0)
            for (int j = 0; j < 16; j++)
                e_pins[j] = m_cur[8 * ((m_ui / 8) * 16 + j) + (m_ui % 8)];
        check("ready",  bus.ready_o, m_run && (m_q.size() < DEPTH));
        check("busy",   busy_o,      (m_ui >= 0) || (m_q.size() > 0));
        check("clk_en", clk_en_o,    m_ui >= 0);
        check("valid",  valid_oPin,  (m_ui >= 0) && ((m_ui % 8) < 4));
        check("pins",   dataPins_o,  e_pins);
        check("sent",   flits_sent_o, 16'(m_sent));
        // Lane deserializer: rebuild byte (16c+j) bit b from lane j.
        if (clk_en_o) begin
            for (int j = 0; j < 16; j++)
                rx_flit[8 * ((rx_ui / 8) * 16 + j) + (rx_ui % 8)] = dataPins_o[j];
            rx_ui++;
            if (rx_ui == 32) begin
                rx_ui = 0;
                if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_flit", rx_flit, rx_q.pop_front());
            end
        end
        if (clk_en_o) en_cnt++;
        if (clk_en_o && !prev_en) en_runs++;
        if (valid_oPin && !prev_v) v_rises++;
        prev_en = clk_en_o; prev_v = valid_oPin;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [511:0] rnd_flit();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = $urandom;
        return f;
    endfunction

    task automatic push(input logic [511:0] d, output int waited);
        waited = 0;
        @(negedge clk); bus.valid_i = 1'b1; bus.data_i = d;
        do begin @(posedge clk); #2; waited++; end
        while (!m_acc && waited < 200);
        if (!m_acc) check("push_timeout", 0, 1);
    endtask

    task automatic drop_valid();
        @(negedge clk); bus.valid_i = 1'b0; bus.data_i = rnd_flit();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(posedge clk); #2; n++; end
        while (busy_o && n < 400);
        if (busy_o) check("idle_timeout", 1, 0);
    endtask

    logic [511:0] hello;
    string        s;
    int           w, tot, cnt, base;
    logic [7:0]   vpat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus.valid_i = 1'b0; bus.data_i = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", bus.ready_o, 0);
        check("rst_pins",  dataPins_o, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #2;
        check("post_rst_ready", bus.ready_o, 1);

        // ---- single "Hello" flit ----
        s = "Hello, World! This is a test. Flit 0";
        for (int n = 0; n < 64; n++)
            hello[8*n +: 8] = (n < s.len()) ? 8'(s[n]) : 8'h20;
        push(hello, w);
        drop_valid();
        @(posedge clk); #2;
        check("hello_latency_en", clk_en_o, 1);
        check("hello_ui0_pins", dataPins_o[1:0], 2'b10);
        cnt = 1; vpat = '0; vpat[0] = valid_oPin;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (!clk_en_o) break;
            if (cnt < 8) vpat[cnt] = valid_oPin;
            cnt++;
        end
        check("hello_en_cycles", cnt, 32);
        check("hello_valid_pat", vpat, 8'h0F);
        check("hello_busy_low", busy_o, 0);
        check("hello_sent", flits_sent_o, 1);

        // ---- back-to-back ----
        en_cnt = 0; en_runs = 0; v_rises = 0; base = flits_sent_o;
        for (int i = 0; i < 3; i++) push(rnd_flit(), w);
        drop_valid();
        wait_idle();
        check("b2b_en_cycles", en_cnt, 96);
        check("b2b_contiguous", en_runs, 1);
        check("b2b_valid_rises", v_rises, 12);
        check("b2b_sent", flits_sent_o - 16'(base), 3);

        // ---- backpressure, 7 flits with valid held ----
        base = flits_sent_o; tot = 0;
        for (int i = 0; i < 7; i++) begin
            push(rnd_flit(), w);
            tot += w;
            if (i == 4) begin
                check("bp_first5_cycles", tot, 5);
                check("bp_full_ready", bus.ready_o, 0);
            end
            if (i == 5) check("bp_refill_full", bus.ready_o, 0);
        end
        drop_valid();
        wait_idle();
        check("bp_sent", flits_sent_o - 16'(base), 7);

        // ---- reset mid-flit ----
        for (int i = 0; i < 3; i++) push(rnd_flit(), w);
        drop_valid();
        for (int i = 0; i < 100 && m_ui != 13; i++) begin @(posedge clk); #2; end
        check("mid_ui13", m_ui, 13);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #2;
        check("mid_rst_pins",  {dataPins_o, valid_oPin, clk_en_o}, 0);
        check("mid_rst_sent",  flits_sent_o, 0);
        check("mid_rst_busy",  busy_o, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #2;
        check("mid_ready", bus.ready_o, 1);
        check("mid_empty", busy_o, 0);

        // ---- random traffic ----
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.valid_i = ($urandom_range(0, 1) == 1);
            bus.data_i  = rnd_flit();
        end
        drop_valid();
        wait_idle();
        check("rx_leftover", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
